// File: rtl/axi4lite_read.sv
// rtl/axi4lite_read.sv - AXI4-Lite read-channel slave feeding a register-side read strobe
//
// Purpose: accepts one AXI4-Lite read at a time, issues a single-cycle
// register read strobe for in-range word addresses, waits RD_LATENCY cycles
// for the register data, then returns it on the R channel (SLVERR and zero
// data for out-of-range words).
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   axi_araddr/arprot/      AXI read address channel (arprot ignored)
//   arvalid/arready
//   axi_rdata/rresp/        AXI read data channel
//   rvalid/rready
//   rd_addr, rd_valid       register-side word index and read strobe
//   rd_data                 register-side read data
//   busy                    high whenever a read is in flight

module axi4lite_read #(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int WORD_LIMIT = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic [2:0]            axi_arprot,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic [ADDR_WIDTH-3:0] rd_addr,
    output logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy
);

    localparam int WA_W  = ADDR_WIDTH - 2;
    localparam int CNT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY);
    localparam logic [WA_W-1:0]  LIMIT    = WA_W'(WORD_LIMIT);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WA_W-1:0]       rd_addr_q, rd_addr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  oor_q, oor_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic [WA_W-1:0] word_idx;
    logic            word_in_range;
    logic            ar_hs;
    logic            r_hs;
    logic            cnt_done;

    // Protection bits and byte offset carry no meaning for word registers.
    logic unused_inputs;
    assign unused_inputs = ^{axi_arprot, axi_araddr[1:0]};

    assign word_idx      = axi_araddr[ADDR_WIDTH-1:2];
    assign word_in_range = (word_idx < LIMIT);
    assign ar_hs         = axi_arvalid && axi_arready;
    assign r_hs          = axi_rvalid && axi_rready;
    assign cnt_done      = (cnt_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ar_hs)    state_d = S_WAIT;
            S_WAIT:  if (cnt_done) state_d = S_RESP;
            S_RESP:  if (r_hs)     state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // FSM outputs. arready is masked by reset so it stays low while reset is
    // held and rises in the very first cycle reset is low.
    always_comb begin
        axi_arready = (state_q == S_IDLE) && !reset;
        axi_rvalid  = (state_q == S_RESP);
        busy        = (state_q != S_IDLE);
    end

    // Datapath next-state
    always_comb begin
        cnt_d      = cnt_q;
        rd_addr_d  = rd_addr_q;
        rd_valid_d = 1'b0;
        oor_d      = oor_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        if (ar_hs) begin
            rd_addr_d  = word_idx;
            rd_valid_d = word_in_range;
            oor_d      = !word_in_range;
            cnt_d      = CNT_LOAD;
        end

        // The counter reaches zero exactly in the cycle the register side
        // presents rd_data, so the sample happens on that same edge.
        if (state_q == S_WAIT) begin
            if (cnt_done) begin
                rdata_d = oor_q ? '0 : rd_data;
                rresp_d = oor_q ? RESP_SLVERR : RESP_OKAY;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            oor_q      <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_valid_q <= rd_valid_d;
            oor_q      <= oor_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign rd_valid  = rd_valid_q;
    assign axi_rdata = rdata_q;
    assign axi_rresp = rresp_q;

endmodule
